// File: rtl/ysyx_040066_if_fetch.sv
// Instruction-fetch stage: issues word fetches to an in-order, variable-latency
// imem port and queues the returned instructions for decode (stall + redirect aware).
module ysyx_040066_if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        block,
  input  logic        jmp,
  input  logic [63:0] jmp_target,
  output logic [63:0] pc_out,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic        instr_error_out,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rerr
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned UW  = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] ifr_ptr_q, ifr_ptr_d, ifw_ptr_q, ifw_ptr_d;
  logic          valid_d;
  logic [31:0]   instr_d;
  logic          instr_err_d;

  // Fetch queue storage and the parallel pc tags of outstanding requests
  logic [63:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic          q_err   [DEPTH];
  logic [63:0]   if_pc   [DEPTH];

  logic          accept_c, grant_c, credit_c, misaligned_c;
  logic          rsp_push_c, mis_push_c, push_c;
  logic [63:0]   push_pc_c;
  logic [31:0]   push_instr_c;
  logic          push_err_c;
  logic [UW-1:0] used_c;

  assign pc_out    = q_pc[rd_ptr_q];
  assign imem_addr = fetch_pc_q;

  // Handshake decode, credit check and next-state computation
  always_comb begin
    accept_c     = valid_out && !block && !jmp;
    used_c       = UW'(inflight_q) + UW'(count_q) - UW'(accept_c);
    credit_c     = used_c < UW'(DEPTH);
    misaligned_c = fetch_pc_q[1:0] != 2'b00;
    imem_req     = !rst && (state_q == S_RUN) && !jmp && !misaligned_c && credit_c;
    grant_c      = imem_req && imem_gnt;
    rsp_push_c   = imem_rvalid && (drop_q == '0) && !jmp;
    mis_push_c   = (state_q == S_RUN) && !jmp && misaligned_c && credit_c && !rsp_push_c;
    push_c       = rsp_push_c || mis_push_c;
    push_pc_c    = mis_push_c ? fetch_pc_q : if_pc[ifr_ptr_q];
    push_instr_c = mis_push_c ? NOP : imem_rdata;
    push_err_c   = mis_push_c ? 1'b1 : imem_rerr;

    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    inflight_d   = inflight_q + CW'(grant_c) - CW'(imem_rvalid);
    drop_d       = drop_q;
    count_d      = count_q + CW'(push_c) - CW'(accept_c);
    rd_ptr_d     = rd_ptr_q + PW'(accept_c);
    wr_ptr_d     = wr_ptr_q + PW'(push_c);
    ifw_ptr_d    = ifw_ptr_q + PW'(grant_c);
    ifr_ptr_d    = ifr_ptr_q + PW'(imem_rvalid);
    instr_d      = instr_out;
    instr_err_d  = instr_error_out;

    if (grant_c) fetch_pc_d = fetch_pc_q + 64'd4;
    if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (accept_c) begin
      instr_d     = q_instr[rd_ptr_q];
      instr_err_d = q_err[rd_ptr_q];
    end
    if (mis_push_c || (rsp_push_c && imem_rerr)) state_d = S_HALT;

    // Redirect: flush the queue and discard every response still owed to us
    if (jmp) begin
      state_d    = S_RUN;
      fetch_pc_d = jmp_target;
      drop_d     = inflight_d;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
    end
    valid_d = count_d != '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_RUN;
      fetch_pc_q      <= RESET_PC;
      inflight_q      <= '0;
      drop_q          <= '0;
      count_q         <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      ifr_ptr_q       <= '0;
      ifw_ptr_q       <= '0;
      valid_out       <= 1'b0;
      instr_out       <= NOP;
      instr_error_out <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      inflight_q      <= inflight_d;
      drop_q          <= drop_d;
      count_q         <= count_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      ifr_ptr_q       <= ifr_ptr_d;
      ifw_ptr_q       <= ifw_ptr_d;
      valid_out       <= valid_d;
      instr_out       <= instr_d;
      instr_error_out <= instr_err_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the counters above
  always_ff @(posedge clk) begin
    if (push_c) begin
      q_pc[wr_ptr_q]    <= push_pc_c;
      q_instr[wr_ptr_q] <= push_instr_c;
      q_err[wr_ptr_q]   <= push_err_c;
    end
    if (grant_c) if_pc[ifw_ptr_q] <= fetch_pc_q;
  end

  queue_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_c && !accept_c && (count_q == CW'(DEPTH))));

  inflight_overflow: assert property (@(posedge clk) disable iff (rst)
    !(grant_c && (inflight_q == CW'(DEPTH))));

endmodule

// File: tb/tb_ysyx_040066_if_fetch.sv
// Bench for ysyx_040066_if_fetch: in-order memory model with random latency/grant,
// an epoch-based reference of the delivered instruction stream, and directed corner cases.
module tb_ysyx_040066_if_fetch;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        block = 1'b0;
  logic        jmp = 1'b0;
  logic [63:0] jmp_target = '0;
  logic [63:0] pc_out;
  logic        valid_out;
  logic [31:0] instr_out;
  logic        instr_error_out;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_rerr = 1'b0;

  ysyx_040066_if_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .block(block), .jmp(jmp), .jmp_target(jmp_target),
    .pc_out(pc_out), .valid_out(valid_out), .instr_out(instr_out),
    .instr_error_out(instr_error_out), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .imem_rerr(imem_rerr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; logic err; } ent_t;
  typedef struct { logic blk; logic req; logic [63:0] addr; logic valid;
                   logic [63:0] pc; logic [31:0] instr; } vec_t;

  mreq_t mq[$];
  ent_t  eq[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  int          epoch = 0;
  logic [63:0] fault_addr = '0;
  logic [63:0] exp_pc = RESET_PC;
  logic [31:0] exp_instr = NOP;
  logic        exp_err = 1'b0;
  logic        halted = 1'b0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; block = 1'b0; jmp = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rerr = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_valid_out", 64'(valid_out), 64'(0));
    chk("rst_imem_req", 64'(imem_req), 64'(0));
    chk("rst_instr_out", 64'(instr_out), 64'(NOP));
    chk("rst_instr_error_out", 64'(instr_error_out), 64'(0));
    mq.delete(); eq.delete();
    epoch++; halted = 1'b0; exp_pc = RESET_PC; exp_instr = NOP; exp_err = 1'b0;
  endtask

  // One clock cycle: drive inputs and memory, check against the reference, advance it
  task automatic step(input logic b, input logic j, input logic [63:0] tgt);
    logic run, acc, exp_req, live;
    int   used;
    ent_t e;
    mreq_t m;
    @(negedge clk);
    rst = 1'b0; block = b; jmp = j; jmp_target = tgt;
    imem_gnt = ($urandom_range(99) < 32'(gnt_pct));
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
      imem_rerr   = (mq[0].addr == fault_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      imem_rerr   = 1'($urandom);
    end
    #1;
    chk("valid_out", 64'(valid_out), 64'(eq.size() != 0));
    if (eq.size() != 0) chk("pc_out", pc_out, eq[0].pc);
    chk("instr_out", 64'(instr_out), 64'(exp_instr));
    chk("instr_error_out", 64'(instr_error_out), 64'(exp_err));
    run     = !halted;
    acc     = (eq.size() != 0) && !b && !j;
    used    = mq.size() + eq.size() - int'(acc);
    exp_req = run && !j && (exp_pc[1:0] == 2'b00) && (used < DEPTH);
    chk("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, exp_pc);

    if (acc) begin
      e = eq.pop_front();
      exp_instr = e.instr;
      exp_err   = e.err;
    end
    live = 1'b0;
    if (imem_rvalid) begin
      m = mq.pop_front();
      if (m.epoch == epoch && !j) begin
        e.pc = m.addr; e.instr = mem_word(m.addr); e.err = (m.addr == fault_addr);
        eq.push_back(e);
        live = 1'b1;
        if (e.err) halted = 1'b1;
      end
    end
    if (run && !j && exp_pc[1:0] != 2'b00 && used < DEPTH && !live) begin
      e.pc = exp_pc; e.instr = NOP; e.err = 1'b1;
      eq.push_back(e);
      halted = 1'b1;
    end
    if (imem_req && imem_gnt) begin
      m.addr = imem_addr; m.epoch = epoch;
      m.due = cyc + int'($urandom_range(32'(lat_max), 32'(lat_min)));
      mq.push_back(m);
    end
    if (exp_req && imem_gnt) exp_pc = exp_pc + 64'd4;
    if (j) begin
      eq.delete(); epoch++; exp_pc = tgt; halted = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vec [6];
    logic [63:0] held_pc;
    logic        found, saw;
    int          reqs;

    for (int k = 0; k < 6; k++) begin
      vec[k].blk   = 1'b0;
      vec[k].req   = 1'b1;
      vec[k].addr  = RESET_PC + 64'(4 * k);
      vec[k].valid = (k >= 2);
      vec[k].pc    = RESET_PC + 64'(4 * (k - 2));
      vec[k].instr = (k >= 3) ? mem_word(RESET_PC + 64'(4 * (k - 3))) : NOP;
    end

    // Startup with 1-cycle memory: fixed pipeline timing
    gnt_pct = 100; lat_min = 1; lat_max = 1; fault_addr = '0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(vec[k].blk, 1'b0, '0);
      chk("tbl_req", 64'(imem_req), 64'(vec[k].req));
      chk("tbl_addr", imem_addr, vec[k].addr);
      chk("tbl_valid", 64'(valid_out), 64'(vec[k].valid));
      if (vec[k].valid) chk("tbl_pc", pc_out, vec[k].pc);
      chk("tbl_instr", 64'(instr_out), 64'(vec[k].instr));
    end

    // Decode stall for 5 cycles: head frozen, issue throttled by credit
    step(1'b1, 1'b0, '0);
    held_pc = pc_out;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, '0);
      chk("blk_pc_hold", pc_out, held_pc);
      chk("blk_valid_hold", 64'(valid_out), 64'(1));
    end
    chk("blk_req_throttled", 64'(imem_req), 64'(0));
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, '0);

    // Redirect with two late responses outstanding
    lat_min = 3; lat_max = 3;
    do_reset();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 64'h8000_1000);
    @(posedge clk); #1;
    chk("jmp_fetch_addr", imem_addr, 64'h8000_1000);
    chk("jmp_valid_cleared", 64'(valid_out), 64'(0));
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 1'b0, '0);
      found = valid_out;
    end
    chk("jmp_first_valid", 64'(found), 64'(1));
    chk("jmp_first_pc", pc_out, 64'h8000_1000);

    // Redirect coinciding with a response while decode is stalled
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mq.size() != 0 && mq[0].due <= cyc) found = 1'b1;
      else step(1'b1, 1'b0, '0);
    end
    chk("rsp_wait", 64'(found), 64'(1));
    step(1'b1, 1'b1, 64'h8000_2000);
    @(posedge clk); #1;
    chk("jmp_rsp_queue_empty", 64'(valid_out), 64'(0));
    chk("jmp_rsp_fetch_addr", imem_addr, 64'h8000_2000);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, '0);

    // Access fault at 0x80000008 halts issue
    lat_min = 1; lat_max = 1; fault_addr = 64'h8000_0008;
    do_reset();
    saw = 1'b0; reqs = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, '0);
      if (instr_error_out) saw = 1'b1;
      if (k >= 8 && imem_req) reqs++;
    end
    chk("fault_entry_seen", 64'(saw), 64'(1));
    chk("fault_no_req", 64'(reqs), 64'(0));

    // Misaligned redirect target yields one error entry, then idles
    step(1'b0, 1'b1, 64'h8000_0002);
    saw = 1'b0; reqs = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, '0);
      if (imem_req) reqs++;
      if (valid_out && pc_out == 64'h8000_0002) saw = 1'b1;
    end
    chk("mis_entry_seen", 64'(saw), 64'(1));
    chk("mis_no_req", 64'(reqs), 64'(0));
    chk("mis_instr", 64'(instr_out), 64'(NOP));
    chk("mis_err", 64'(instr_error_out), 64'(1));

    // Randomised traffic against the reference
    lat_min = 1; lat_max = 4; gnt_pct = 70;
    for (int r = 0; r < 5; r++) begin
      fault_addr = RESET_PC + 64'(4 * $urandom_range(0, 200));
      do_reset();
      for (int k = 0; k < 800; k++) begin
        logic        b, j;
        logic [63:0] t;
        b = ($urandom_range(99) < 30);
        j = ($urandom_range(99) < 3);
        t = RESET_PC + 64'(4 * $urandom_range(0, 63));
        if ($urandom_range(19) == 0) t = t + 64'($urandom_range(1, 3));
        step(b, j, t);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_040066_if_fetch.md
Name: ysyx_040066_if_fetch

Overview:
- Instruction-fetch stage. Produces the pc / valid / instruction / instruction-error stream that the decode stage consumes.
- Issues 32-bit fetches to a variable-latency, in-order instruction-memory port and buffers returned instructions in a small queue.
- Honours the decode stall (block) and redirects (jmp with target) from downstream.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
- DEPTH, 4, fetch-queue entries; also the cap on in-flight plus queued fetches (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- block  in  1  decode stall; holds decode's outputs.
- jmp  in  1  redirect request; priority over everything except rst.
- jmp_target  in  64  redirect pc, valid while jmp.
- pc_out  out  64  pc of the queue head.
- valid_out  out  1  queue head valid.
- instr_out  out  32  instruction of the entry accepted at the previous edge.
- instr_error_out  out  1  fetch error of that entry.
- imem_req  out  1  fetch request.
- imem_addr  out  64  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid, in order, ≥1 cycle after grant.
- imem_rdata  in  32  response instruction.
- imem_rerr  in  1  response access fault.

Behaviour:
- Reset values:
  - fetch pc = RESET_PC; queue empty; inflight = 0; drop = 0; state RUN.
  - valid_out = 0; pc_out = queue-head storage, don't-care while invalid.
  - instr_out = 32'h0000_0013 (nop); instr_error_out = 0; imem_req = 0.
- Decode-side timing:
  - pc_out/valid_out come from the queue head in cycle N.
  - Accept at posedge = valid_out && ~block && ~jmp. Accept pops the head and registers its instr/err into instr_out/instr_error_out. Decode therefore sees the instruction in cycle N+1, one cycle after it captured the pc.
  - instr_out/instr_error_out change only on accept.
  - While block = 1, the head, pc_out and valid_out hold.
- Issue rule: imem_req = (state==RUN) && ~jmp && (inflight + count − accept < DEPTH), where count is queue occupancy.
  - imem_addr = fetch pc, combinational from the register.
  - On req && gnt: fetch pc += 4 and inflight += 1.
  - Request and address may change on any cycle without gnt.
- Response: on imem_rvalid, inflight −= 1.
  - If drop > 0: the response is discarded and drop −= 1.
  - Otherwise push {pc tag, rdata, rerr}. The pc tag is held in a parallel in-flight pc FIFO of depth DEPTH.
  - Push and accept in the same cycle is legal at any occupancy. The credit rule guarantees no overflow; an assertion flags overflow.
- Redirect (jmp = 1 at posedge, independent of block):
  - Queue flushed; valid_out = 0 next cycle.
  - drop ← inflight after this cycle's grant/response. A response arriving in the jmp cycle is dropped. A grant in the jmp cycle is impossible because req is forced 0.
  - fetch pc ← jmp_target; state ← RUN.
  - instr_out/instr_error_out unchanged.
- Misaligned target (fetch pc[1:0] != 0 in RUN):
  - No memory request.
  - Push a single entry {pc, 32'h0000_0013, err=1} once credit is available.
  - state ← HALT.
- Fault response: a pushed entry with rerr = 1 sets state ← HALT. Further issue stops; already in-flight responses are still queued.
- HALT leaves only on jmp (→RUN) or rst.
- States:
  - RUN: issue per rule.
  - HALT: no issue; the queue drains normally.
- Reset mid-operation: all state returns to reset values at the edge. Any memory responses still in flight after reset are the memory's responsibility; the memory is reset together with this block.
- inflight and drop are clog2(DEPTH)+1 bits. Fetch pc wraps modulo 2^64.

Test Plan:
- Reset, memory with 1-cycle latency, block = 0 → imem_addr 0x80000000, 0x80000004, …; valid_out first high 2 cycles after rst falls; one instruction accepted per cycle after that; instr_out follows pc_out by exactly one cycle.
- Steady stream with block held high 5 cycles → pc_out and valid_out frozen; imem_req drops once inflight + count = 4; no queue overflow; resumes without loss or duplication.
- 3-cycle latency with 2 in flight, then jmp to 0x80001000 → the 2 late responses are discarded; the next valid_out has pc_out 0x80001000; the next fetch address is 0x80001000.
- jmp in the same cycle as imem_rvalid and block = 1 → the response is dropped, the queue is empty next cycle, and the redirect is taken.
- Response with imem_rerr = 1 at pc 0x80000008 → that entry is accepted with instr_error_out = 1; no further req until jmp.
- jmp_target 0x80000002 → no req; entry {0x80000002, 0x00000013, err=1} is delivered; then idle until the next jmp.
